// File: rtl/mem_port_arbiter.sv
// Arbitrates a single fixed-latency memory port between instruction fetch and load/store.
// Data side wins by default; a starvation counter forces a fetch grant after MAX_WAIT losses.
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [3:0] RdLatC   = 4'(RD_LAT);
    localparam logic [3:0] MaxWaitC = 4'(MAX_WAIT);

    state_e        state_q, state_d;
    logic          own_d_q, own_d_d;
    logic [3:0]    lat_q, lat_d;
    logic [3:0]    starve_q, starve_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        own_d_d     = own_d_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_req && (starve_q < MaxWaitC)) begin
                    own_d_d     = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    state_d     = StIssue;
                    // starve_q < MaxWaitC here, so the increment saturates at MAX_WAIT
                    starve_d    = if_req ? starve_q + 4'd1 : 4'd0;
                end else if (if_req) begin
                    own_d_d    = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    state_d    = StIssue;
                    starve_d   = 4'd0;
                end
            end
            StIssue: begin
                mem_we_d = 1'b0;
                if (mem_we_q) begin
                    d_ack_d  = own_d_q;
                    if_ack_d = ~own_d_q;
                    state_d  = StResp;
                end else begin
                    lat_d   = RdLatC;
                    state_d = StWait;
                end
            end
            StWait: begin
                // lat_q reaches 1 in the cycle RD_LAT cycles after ISSUE
                if (lat_q == 4'd1) begin
                    if (own_d_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_ack_d   = 1'b1;
                    end
                    lat_d   = 4'd0;
                    state_d = StResp;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            own_d_q     <= 1'b0;
            lat_q       <= 4'd0;
            starve_q    <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            own_d_q     <= own_d_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = busy_q;

endmodule
